// File: rtl/imm_extract_stage.sv
// imm_extract_stage: LEGv8 immediate classify/extend stage with a 2-entry skid buffer.
// Optional IMM_BYTE_OFFSET_EN scales B/CB immediates from word offsets to byte offsets.
module imm_extract_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [63:0] out_imm,
  output logic [2:0]  out_kind
);
  typedef enum logic [$clog2(DEPTH+1)-1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  kind;
  } beat_t;
`ifdef IMM_BYTE_OFFSET_EN
  localparam int BR_SHIFT = 2;
`else
  localparam int BR_SHIFT = 0;
`endif
  logic        is_b, is_cb, is_d, is_i, acc, emit;
  logic [63:0] b_imm, cb_imm, d_imm, i_imm;
  beat_t       in_beat, main_q, main_d, skid_q, skid_d;
  state_t      state_q, state_d;
  logic        out_valid_q, in_ready_q;
  assign is_b   = in_instr[30:26] == 5'b00101;
  assign is_cb  = in_instr[31:24] inside {8'hB4, 8'hB5, 8'h54};
  assign is_d   = in_instr[31:21] inside {11'h7C2, 11'h7C0};
  assign is_i   = in_instr[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4};
  assign b_imm  = {{38{in_instr[25]}}, in_instr[25:0]} << BR_SHIFT;
  assign cb_imm = {{45{in_instr[23]}}, in_instr[23:5]} << BR_SHIFT;
  assign d_imm  = {{55{in_instr[20]}}, in_instr[20:12]};
  assign i_imm  = {52'd0, in_instr[21:10]};
  assign in_beat.instr = in_instr;
  assign in_beat.pc    = in_pc;
  assign in_beat.kind  = is_b ? 3'd4 : is_cb ? 3'd3 : is_d ? 3'd2 : is_i ? 3'd1 : 3'd0;
  assign in_beat.imm   = is_b ? b_imm : is_cb ? cb_imm : is_d ? d_imm : is_i ? i_imm : 64'd0;
  assign acc  = in_valid && in_ready_q;
  assign emit = out_valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (state_q == EMPTY) begin
      if (acc) begin
        main_d  = in_beat;
        state_d = ONE;
      end
    end else if (state_q == ONE) begin
      if (acc && emit) begin
        main_d = in_beat;
      end else if (acc) begin
        skid_d  = in_beat;
        state_d = FULL;
      end else if (emit) begin
        state_d = EMPTY;
      end
    end else if (emit) begin
      main_d  = skid_q;
      state_d = ONE;
    end
  end
  // Handshake flags are registered copies of the next state so neither depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= state_d != EMPTY;
      in_ready_q  <= state_d != FULL;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_imm   = main_q.imm;
  assign out_kind  = main_q.kind;
endmodule

// File: tb/tb_imm_extract_stage.sv
// tb_imm_extract_stage: directed self-checking bench for imm_extract_stage.
module tb_imm_extract_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_instr = '0, out_instr;
  logic [63:0] in_pc = '0, out_pc, out_imm;
  logic [2:0]  out_kind;
  int errors = 0, checks = 0;
`ifdef IMM_BYTE_OFFSET_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  imm_extract_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm), .out_kind(out_kind)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (out_imm !== 64'd0) begin errors++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
    checks++; if (out_kind !== 3'd0) begin errors++; $display("FAIL reset_out_kind got %0d want 0", out_kind); end
    rst_n = 1'b1;
  endtask
  task automatic test_kinds();
    logic [31:0] vi[10] = '{32'hF85FC041, 32'h913FFC20, 32'h17FFFFFF, 32'hB4800000, 32'hF8008020,
                            32'h14000010, 32'h54000043, 32'h8B020020, 32'h97FFFFFE, 32'hB5000020};
    logic [2:0]  vk[10] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd2, 3'd4, 3'd3, 3'd0, 3'd4, 3'd3};
    logic [63:0] vr[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFC_0000,
                            64'h8, 64'h10, 64'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
    logic [63:0] vs[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFF0_0000,
                            64'h8, 64'h40, 64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4};
    logic [63:0] exp_imm;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = vi[i];
      in_pc    = 64'h1000 + 64'(i * 4);
      exp_imm  = SH ? vs[i] : vr[i];
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kind_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_kind !== vk[i]) begin errors++; $display("FAIL kind[%0d] got %0d want %0d", i, out_kind, vk[i]); end
      checks++; if (out_imm !== exp_imm) begin errors++; $display("FAIL imm[%0d] got %h want %h", i, out_imm, exp_imm); end
      checks++; if (out_instr !== vi[i]) begin errors++; $display("FAIL instr[%0d] got %h want %h", i, out_instr, vi[i]); end
      checks++; if (out_pc !== 64'h1000 + 64'(i * 4)) begin errors++; $display("FAIL pc[%0d] got %h want %h", i, out_pc, 64'h1000 + 64'(i * 4)); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kinds_drain got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hF85FC041; in_pc = 64'hA0;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'hA0) begin errors++; $display("FAIL b2b_a got v=%b pc=%h want v=1 pc=a0", out_valid, out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
    in_instr = 32'h913FFC20; in_pc = 64'hB0;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", in_ready); end
    checks++; if (out_pc !== 64'hA0) begin errors++; $display("FAIL b2b_hold1 got %h want a0", out_pc); end
    in_instr = 32'hB4800000; in_pc = 64'hC0;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", in_ready); end
    checks++; if (out_pc !== 64'hA0 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || out_kind !== 3'd2) begin
      errors++; $display("FAIL b2b_hold2 got pc=%h imm=%h kind=%0d want a0/fffffffffffffffc/2", out_pc, out_imm, out_kind); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'hB0 || out_imm !== 64'hFFF) begin
      errors++; $display("FAIL b2b_b got v=%b pc=%h imm=%h want 1/b0/fff", out_valid, out_pc, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'hC0 || out_kind !== 3'd3) begin
      errors++; $display("FAIL b2b_c got v=%b pc=%h kind=%0d want 1/c0/3", out_valid, out_pc, out_kind); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h17FFFFFF; in_pc = 64'h200;
    step();
    in_pc = 64'h204;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got %b want 0", in_ready); end
    flush = 1'b1; in_pc = 64'h208;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got %b want 1", in_ready); end
    flush = 1'b0; in_pc = 64'h20C;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h20C) begin errors++; $display("FAIL flush_one_pre got v=%b pc=%h want 1/20c", out_valid, out_pc); end
    flush = 1'b1; out_ready = 1'b1; in_pc = 64'h210;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_one got v=%b r=%b want 0/1", out_valid, in_ready); end
    flush = 1'b0; in_instr = 32'hF8008020; in_pc = 64'h214;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h214 || out_imm !== 64'h8) begin
      errors++; $display("FAIL flush_after got v=%b pc=%h imm=%h want 1/214/8", out_valid, out_pc, out_imm); end
    in_valid = 1'b0;
    step();
  endtask
  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h913FFC20; in_pc = 64'h300;
    step();
    in_pc = 64'h304;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_flags got v=%b r=%b want 0/1", out_valid, in_ready); end
    checks++; if (out_pc !== 64'd0 || out_imm !== 64'd0 || out_instr !== 32'd0 || out_kind !== 3'd0) begin
      errors++; $display("FAIL arst_data got pc=%h imm=%h instr=%h kind=%0d want zeros", out_pc, out_imm, out_instr, out_kind); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_release got %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_kinds();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
